// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong buffer that re-emits bit-reversed FFT frames in natural bin order
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   in_r, in_i, in_valid,   sample stream from the last FFT stage (bit-reversed order);
//   in_sof, in_ready        in_sof marks the first sample, in_ready is back-pressure
//   out_r, out_i, out_valid natural-order sample stream with valid/ready handshake;
//   out_sof, out_eof,       out_sof flags bin 0, out_eof flags bin N-1
//   out_ready
//   sync_err                sticky flag, set when an in_sof abandons a partial frame
module fft_bitrev_reorder #(
    parameter int data_width = 14,
    parameter int log2_n     = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [data_width-1:0] in_r,
    input  logic [data_width-1:0] in_i,
    input  logic                  in_valid,
    input  logic                  in_sof,
    output logic                  in_ready,
    output logic [data_width-1:0] out_r,
    output logic [data_width-1:0] out_i,
    output logic                  out_valid,
    output logic                  out_sof,
    output logic                  out_eof,
    input  logic                  out_ready,
    output logic                  sync_err
);

    localparam int N_PTS = 1 << log2_n;
    localparam int WW    = 2 * data_width;

    localparam logic [log2_n-1:0] CNT_ONE  = {{(log2_n-1){1'b0}}, 1'b1};
    localparam logic [log2_n-1:0] CNT_LAST = {log2_n{1'b1}};

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_e;

    function automatic logic [log2_n-1:0] bitrev(input logic [log2_n-1:0] a);
        logic [log2_n-1:0] r;
        for (int k = 0; k < log2_n; k++) begin
            r[k] = a[log2_n-1-k];
        end
        return r;
    endfunction

    bank_state_e bank_q [2];
    bank_state_e bank_d [2];

    logic              rdy_en_q;
    logic              wr_bank_q, wr_bank_d;
    logic [log2_n-1:0] wr_cnt_q, wr_cnt_d;
    logic              sync_err_q, sync_err_d;

    // Read addresses are issued from their own bank pointer so the next frame can
    // start prefetching while the tail of the current one is still in the output
    // pipeline; rd_bank only moves when the last sample is accepted downstream.
    logic              iss_bank_q, iss_bank_d;
    logic [log2_n-1:0] iss_cnt_q, iss_cnt_d;
    logic              rd_bank_q, rd_bank_d;

    // Stage 1: RAM read register plus the framing tags of the word in flight.
    logic [WW-1:0]     rdata_q;
    logic              r_vld_q, r_vld_d;
    logic              r_sof_q, r_sof_d;
    logic              r_eof_q, r_eof_d;

    // Stage 2: output register.
    logic                  out_valid_q, out_valid_d;
    logic                  out_sof_q, out_sof_d;
    logic                  out_eof_q, out_eof_d;
    logic [data_width-1:0] out_r_q, out_r_d;
    logic [data_width-1:0] out_i_q, out_i_d;

    logic [WW-1:0] mem_q [2*N_PTS];

    logic              wr_fire;
    logic [log2_n-1:0] wr_addr;
    logic              out_fire;
    logic              out_load;
    logic              iss_ok;
    logic              iss_fire;

    always_comb begin
        in_ready = rdy_en_q && ((bank_q[wr_bank_q] == BANK_EMPTY) ||
                                (bank_q[wr_bank_q] == BANK_FILLING));
        wr_fire  = in_valid && in_ready;
        // A resync sample always lands on bin 0, which is address 0 in either order.
        wr_addr  = in_sof ? '0 : bitrev(wr_cnt_q);

        out_fire = out_valid_q && out_ready;
        out_load = r_vld_q && (!out_valid_q || out_ready);
        // Keep issuing from a bank that is mid-drain; a fresh bank must be FULL.
        iss_ok   = (bank_q[iss_bank_q] == BANK_FULL) ||
                   ((bank_q[iss_bank_q] == BANK_DRAINING) && (iss_cnt_q != '0));
        iss_fire = iss_ok && (!r_vld_q || out_load);
    end

    always_comb begin
        bank_d[0]   = bank_q[0];
        bank_d[1]   = bank_q[1];
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        sync_err_d  = sync_err_q;
        iss_bank_d  = iss_bank_q;
        iss_cnt_d   = iss_cnt_q;
        rd_bank_d   = rd_bank_q;
        r_vld_d     = r_vld_q;
        r_sof_d     = r_sof_q;
        r_eof_d     = r_eof_q;
        out_valid_d = out_valid_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;

        // Write side. The three bank transitions below always touch different
        // banks: the write bank is EMPTY/FILLING, the issue bank is FULL when it
        // changes, and the read bank is DRAINING when it empties.
        if (wr_fire) begin
            if (in_sof) begin
                wr_cnt_d          = CNT_ONE;
                bank_d[wr_bank_q] = BANK_FILLING;
                if (wr_cnt_q != '0) begin
                    sync_err_d = 1'b1;
                end
            end else if (wr_cnt_q == CNT_LAST) begin
                wr_cnt_d          = '0;
                bank_d[wr_bank_q] = BANK_FULL;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_cnt_d          = wr_cnt_q + CNT_ONE;
                bank_d[wr_bank_q] = BANK_FILLING;
            end
        end

        // Read address issue into stage 1.
        if (iss_fire) begin
            if (bank_q[iss_bank_q] == BANK_FULL) begin
                bank_d[iss_bank_q] = BANK_DRAINING;
            end
            iss_cnt_d = iss_cnt_q + CNT_ONE;
            if (iss_cnt_q == CNT_LAST) begin
                iss_bank_d = ~iss_bank_q;
            end
            r_vld_d = 1'b1;
            r_sof_d = (iss_cnt_q == '0);
            r_eof_d = (iss_cnt_q == CNT_LAST);
        end else if (out_load) begin
            r_vld_d = 1'b0;
        end

        // Output register: holds while stalled, refills from stage 1 otherwise.
        if (out_load) begin
            out_valid_d = 1'b1;
            out_sof_d   = r_sof_q;
            out_eof_d   = r_eof_q;
            out_r_d     = rdata_q[WW-1:data_width];
            out_i_d     = rdata_q[data_width-1:0];
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        // A bank is only released once its last sample has left the block, so
        // the write side cannot reuse it while samples are still downstream.
        if (out_fire && out_eof_q) begin
            bank_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank_q[0]   <= BANK_EMPTY;
            bank_q[1]   <= BANK_EMPTY;
            rdy_en_q    <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            sync_err_q  <= 1'b0;
            iss_bank_q  <= 1'b0;
            iss_cnt_q   <= '0;
            rd_bank_q   <= 1'b0;
            r_vld_q     <= 1'b0;
            r_sof_q     <= 1'b0;
            r_eof_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
        end else begin
            bank_q[0]   <= bank_d[0];
            bank_q[1]   <= bank_d[1];
            rdy_en_q    <= 1'b1;
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            sync_err_q  <= sync_err_d;
            iss_bank_q  <= iss_bank_d;
            iss_cnt_q   <= iss_cnt_d;
            rd_bank_q   <= rd_bank_d;
            r_vld_q     <= r_vld_d;
            r_sof_q     <= r_sof_d;
            r_eof_q     <= r_eof_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
        end
    end

    // Frame RAM: both banks in one array, addressed as {bank, bin}. The read
    // register only updates on issue, so a stalled word stays put.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem_q[{wr_bank_q, wr_addr}] <= {in_r, in_i};
        end
        if (iss_fire) begin
            rdata_q <= mem_q[{iss_bank_q, iss_cnt_q}];
        end
    end

    assign out_r     = out_r_q;
    assign out_i     = out_i_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - self-checking bench for fft_bitrev_reorder with N=8
module tb_fft_bitrev_reorder;

    localparam int DW = 14;
    localparam int LN = 3;
    localparam int NP = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_r = '0;
    logic [DW-1:0] in_i = '0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_r;
    logic [DW-1:0] out_i;
    logic          out_valid;
    logic          out_sof;
    logic          out_eof;
    logic          out_ready = 1'b1;
    logic          sync_err;

    fft_bitrev_reorder #(.data_width(DW), .log2_n(LN)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_r      (in_r),
        .in_i      (in_i),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_ready (out_ready),
        .sync_err  (sync_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    int cyc    = 0;

    // Natural bin b holds the input sample that arrived at position br[b].
    int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic [29:0] got_q [$];
    logic [29:0] exp_q [$];
    int          acc_cyc [$];

    typedef struct {
        logic vld;
        logic sof;
        int   r;
        int   i;
        logic e_vld;
        logic e_sof;
        logic e_eof;
        int   e_r;
        int   e_i;
        logic e_irdy;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on the design", name);
    endtask

    // Output monitor: samples mid-cycle, after the driver has settled.
    always begin
        @(negedge clock);
        #2;
        cyc++;
        if (!reset && out_valid && out_ready) begin
            got_q.push_back({out_sof, out_eof, out_r, out_i});
            acc_cyc.push_back(cyc);
        end
    end

    task automatic expect_frame(input int rbase, input int ibase);
        for (int b = 0; b < NP; b++) begin
            exp_q.push_back({(b == 0), (b == NP-1), 14'(rbase + br[b]), 14'(ibase + br[b])});
        end
    endtask

    task automatic feed(input int rbase, input int ibase, input int cnt, input bit rnd);
        int guard;
        for (int p = 0; p < cnt; p++) begin
            guard = 0;
            while (!in_ready) begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
                stalls++;
                @(negedge clock);
                if (rnd) out_ready = 1'($urandom_range(0, 1));
                guard++;
                if (guard > 2000) begin
                    timeout_fail("feed");
                    return;
                end
            end
            in_valid = 1'b1;
            in_sof   = (p == 0);
            in_r     = 14'(rbase + p);
            in_i     = 14'(ibase + p);
            @(negedge clock);
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_out(input int n, input bit rnd);
        int guard = 0;
        while (got_q.size() < n && guard < 4000) begin
            @(negedge clock);
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            guard++;
        end
        out_ready = 1'b1;
        repeat (4) @(negedge clock);
        if (got_q.size() < n) timeout_fail("wait_out");
    endtask

    task automatic compare_sb(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            check($sformatf("%s_item%0d", tag, k), got_q[k], exp_q[k]);
        end
        got_q.delete();
        exp_q.delete();
        acc_cyc.delete();
    endtask

    initial begin
        int guard;
        int j;

        for (int k = 0; k < 19; k++) begin
            j = k - 9;
            tbl[k].vld    = (k < NP);
            tbl[k].sof    = (k == 0);
            tbl[k].r      = k;
            tbl[k].i      = 100 + k;
            tbl[k].e_vld  = (k >= 9 && k <= 16);
            tbl[k].e_sof  = (j == 0);
            tbl[k].e_eof  = (j == NP-1);
            tbl[k].e_r    = (j >= 0 && j < NP) ? br[j] : 0;
            tbl[k].e_i    = (j >= 0 && j < NP) ? 100 + br[j] : 0;
            tbl[k].e_irdy = 1'b1;
        end

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eof", out_eof, 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_i", out_i, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        check("rel_in_ready_low", in_ready, 0);
        @(negedge clock);
        check("rel_in_ready_high", in_ready, 1);

        // Test 1: single frame, cycle-exact table.
        expect_frame(0, 100);
        for (int k = 0; k < 19; k++) begin
            in_valid  = tbl[k].vld;
            in_sof    = tbl[k].sof;
            in_r      = tbl[k].vld ? 14'(tbl[k].r) : '0;
            in_i      = tbl[k].vld ? 14'(tbl[k].i) : '0;
            out_ready = 1'b1;
            @(negedge clock);
            check($sformatf("t1_row%0d_valid", k), out_valid, tbl[k].e_vld);
            check($sformatf("t1_row%0d_in_ready", k), in_ready, tbl[k].e_irdy);
            if (tbl[k].e_vld) begin
                check($sformatf("t1_row%0d_r", k), out_r, tbl[k].e_r);
                check($sformatf("t1_row%0d_i", k), out_i, tbl[k].e_i);
                check($sformatf("t1_row%0d_sof", k), out_sof, tbl[k].e_sof);
                check($sformatf("t1_row%0d_eof", k), out_eof, tbl[k].e_eof);
            end
        end
        compare_sb("t1");

        // Test 2: back-to-back frames with out_ready held high. The third frame
        // waits two cycles for the first bank to empty; after that the write
        // completion and the drain completion coincide and in_ready stays up.
        stalls = 0;
        for (int f = 0; f < 3; f++) begin
            expect_frame(200 + 8*f, 500 + 8*f);
            feed(200 + 8*f, 500 + 8*f, NP, 1'b0);
        end
        check("t2_in_ready_after_simul", in_ready, 1);
        check("t2_stalls", stalls, 2);
        wait_out(3*NP, 1'b0);
        if (acc_cyc.size() >= 3*NP) begin
            check("t2_gap_frames01", acc_cyc[2*NP-1] - acc_cyc[0], 2*NP-1);
            check("t2_gap_frame2", acc_cyc[3*NP-1] - acc_cyc[2*NP], NP-1);
        end
        compare_sb("t2");

        // Test 3: two frames with the output stalled.
        out_ready = 1'b0;
        expect_frame(0, 100);
        expect_frame(300, 400);
        feed(0, 100, NP, 1'b0);
        feed(300, 400, NP, 1'b0);
        check("t3_in_ready_full", in_ready, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check($sformatf("t3_hold%0d_valid", k), out_valid, 1);
            check($sformatf("t3_hold%0d_r", k), out_r, 0);
            check($sformatf("t3_hold%0d_sof", k), out_sof, 1);
            check($sformatf("t3_hold%0d_in_ready", k), in_ready, 0);
        end
        out_ready = 1'b1;
        for (int e = 1; e <= NP; e++) begin
            @(negedge clock);
            if (e == NP-1) check("t3_in_ready_before", in_ready, 0);
            if (e == NP)   check("t3_in_ready_after", in_ready, 1);
        end
        wait_out(2*NP, 1'b0);
        compare_sb("t3");

        // Test 4: random out_ready over 20 frames.
        for (int f = 0; f < 20; f++) begin
            expect_frame(16*f, 8000 + 16*f);
            feed(16*f, 8000 + 16*f, NP, 1'b1);
        end
        wait_out(20*NP, 1'b1);
        compare_sb("t4");
        check("t4_sync_err_clear", sync_err, 0);

        // Test 5: in_sof arrives after 5 samples of a frame.
        feed(50, 60, 5, 1'b0);
        check("t5_sync_err_before", sync_err, 0);
        expect_frame(600, 700);
        feed(600, 700, NP, 1'b0);
        check("t5_sync_err_set", sync_err, 1);
        wait_out(NP, 1'b0);
        compare_sb("t5");
        check("t5_sync_err_sticky", sync_err, 1);

        // Test 6: reset while bin 3 is presented.
        feed(1200, 1300, NP, 1'b0);
        guard = 0;
        while (!(out_valid && out_sof) && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 50) timeout_fail("t6_sof");
        repeat (3) @(negedge clock);
        check("t6_bin3_r", out_r, 1200 + br[3]);
        #1 reset = 1'b1;
        #1;
        check("t6_async_valid", out_valid, 0);
        check("t6_async_r", out_r, 0);
        check("t6_async_sync_err", sync_err, 0);
        check("t6_async_in_ready", in_ready, 0);
        @(negedge clock);
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        acc_cyc.delete();
        check("t6_rel_in_ready_low", in_ready, 0);
        @(negedge clock);
        check("t6_rel_in_ready_high", in_ready, 1);
        expect_frame(1500, 1600);
        feed(1500, 1600, NP, 1'b0);
        wait_out(NP, 1'b0);
        compare_sb("t6");
        check("t6_sync_err_after", sync_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
